// File: rtl/mmu_arbiter_if.sv
// Requester and slave-side signal bundle for mmu_arbiter.
// slave: the arbiter's view; master: the environment's view (requesters plus memory slave).
interface mmu_arbiter_if;
  logic        M0_REQ,        M1_REQ;
  logic [31:0] M0_ADDR,       M1_ADDR;
  logic        M0_WRITE,      M1_WRITE;
  logic [2:0]  M0_SIZE,       M1_SIZE;
  logic [2:0]  M0_BURST,      M1_BURST;
  logic [31:0] M0_WRITE_DATA, M1_WRITE_DATA;
  logic        M0_GNT,        M1_GNT;
  logic        M0_WACK,       M1_WACK;
  logic        M0_RVALID,     M1_RVALID;
  logic [31:0] M0_READ_DATA,  M1_READ_DATA;
  logic        M0_DONE,       M1_DONE;
  logic        M0_ERR,        M1_ERR;

  logic        S_SELX;
  logic        S_WRITE;
  logic [31:0] S_ADDR;
  logic [31:0] S_WRITE_DATA;
  logic [2:0]  S_SIZE;
  logic [2:0]  S_BURST;
  logic [2:0]  S_TRANS;
  logic [31:0] S_READ_DATA;
  logic        S_READYOUT;
  logic        S_RESP;
  logic        S_TRANSFER_COMPLETE;

  modport slave (
    input  M0_REQ, M1_REQ, M0_ADDR, M1_ADDR, M0_WRITE, M1_WRITE,
           M0_SIZE, M1_SIZE, M0_BURST, M1_BURST, M0_WRITE_DATA, M1_WRITE_DATA,
           S_READ_DATA, S_READYOUT, S_RESP, S_TRANSFER_COMPLETE,
    output M0_GNT, M1_GNT, M0_WACK, M1_WACK, M0_RVALID, M1_RVALID,
           M0_READ_DATA, M1_READ_DATA, M0_DONE, M1_DONE, M0_ERR, M1_ERR,
           S_SELX, S_WRITE, S_ADDR, S_WRITE_DATA, S_SIZE, S_BURST, S_TRANS
  );

  modport master (
    output M0_REQ, M1_REQ, M0_ADDR, M1_ADDR, M0_WRITE, M1_WRITE,
           M0_SIZE, M1_SIZE, M0_BURST, M1_BURST, M0_WRITE_DATA, M1_WRITE_DATA,
           S_READ_DATA, S_READYOUT, S_RESP, S_TRANSFER_COMPLETE,
    input  M0_GNT, M1_GNT, M0_WACK, M1_WACK, M0_RVALID, M1_RVALID,
           M0_READ_DATA, M1_READ_DATA, M0_DONE, M1_DONE, M0_ERR, M1_ERR,
           S_SELX, S_WRITE, S_ADDR, S_WRITE_DATA, S_SIZE, S_BURST, S_TRANS
  );
endinterface

// File: rtl/mmu_arbiter.sv
// Two-master arbiter and burst sequencer for the mmu_unit slave: grants one
// requester at a time and issues its NONSEQ/SEQ beats, then pulses DONE.
module mmu_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic         CLK,
  input  logic         RSTN,
  mmu_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_NONSEQ = 2'd1;
  localparam logic [1:0] ST_SEQ    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic [2:0] TRANSFER_IDLE   = 3'd0;
  localparam logic [2:0] TRANSFER_NONSEQ = 3'd2;
  localparam logic [2:0] TRANSFER_SEQ    = 3'd3;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [31:0]      addr_q, addr_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;
  logic [2:0]       burst_q, burst_d;
  logic             selx_q, selx_d;
  logic [2:0]       trans_q, trans_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       wack_q, wack_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic [1:0]       req;
  logic [1:0]       owner_oh_d;
  logic             win;
  logic             issuing;
  logic             abort;

  function automatic logic [CNT_W-1:0] beats_of(input logic [2:0] burst);
    case (burst[2:1])
      2'd0:    return CNT_W'(1);
      2'd1:    return CNT_W'(4);
      2'd2:    return CNT_W'(8);
      default: return CNT_W'(16);
    endcase
  endfunction

  // Next state, latched descriptor and next-cycle output values.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    beats_d      = beats_q;
    addr_d       = addr_q;
    write_d      = write_q;
    size_d       = size_q;
    burst_d      = burst_q;
    win          = 1'b0;
    req          = {bus.M1_REQ, bus.M0_REQ};
    issuing      = (state_q == ST_NONSEQ) || (state_q == ST_SEQ);
    abort        = issuing && bus.S_RESP;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
          end else begin
            win = req[1];
          end
          owner_d = win;
          addr_d  = win ? bus.M1_ADDR  : bus.M0_ADDR;
          write_d = win ? bus.M1_WRITE : bus.M0_WRITE;
          size_d  = win ? bus.M1_SIZE  : bus.M0_SIZE;
          burst_d = win ? bus.M1_BURST : bus.M0_BURST;
          beats_d = beats_of(burst_d);
          state_d = ST_NONSEQ;
        end
      end
      ST_NONSEQ: begin
        beat_cnt_d = CNT_W'(1);
        state_d    = (abort || beats_q == CNT_W'(1)) ? ST_DRAIN : ST_SEQ;
      end
      ST_SEQ: begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (abort || beat_cnt_q == beats_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        last_grant_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    owner_oh_d = owner_d ? 2'b10 : 2'b01;
    selx_d     = (state_d == ST_NONSEQ) || (state_d == ST_SEQ);
    case (state_d)
      ST_NONSEQ: trans_d = TRANSFER_NONSEQ;
      ST_SEQ:    trans_d = TRANSFER_SEQ;
      default:   trans_d = TRANSFER_IDLE;
    endcase
    gnt_d    = (state_d != ST_IDLE) ? owner_oh_d : 2'b00;
    wack_d   = (selx_d && write_d) ? owner_oh_d : 2'b00;
    rvalid_d = (issuing && !write_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    done_d   = (state_d == ST_DRAIN) ? owner_oh_d : 2'b00;
    err_d    = (state_d == ST_DRAIN && abort) ? owner_oh_d : 2'b00;
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      beats_q      <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      burst_q      <= '0;
      selx_q       <= 1'b0;
      trans_q      <= TRANSFER_IDLE;
      gnt_q        <= '0;
      wack_q       <= '0;
      rvalid_q     <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_q      <= beats_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      selx_q       <= selx_d;
      trans_q      <= trans_d;
      gnt_q        <= gnt_d;
      wack_q       <= wack_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.S_SELX  = selx_q;
  assign bus.S_TRANS = trans_q;
  assign bus.S_ADDR  = addr_q;
  assign bus.S_WRITE = write_q;
  assign bus.S_SIZE  = size_q;
  assign bus.S_BURST = burst_q;

  // Write data and read data are steered through without a register stage.
  assign bus.S_WRITE_DATA = selx_q ? (owner_q ? bus.M1_WRITE_DATA : bus.M0_WRITE_DATA) : '0;
  assign bus.M0_READ_DATA = rvalid_q[0] ? bus.S_READ_DATA : '0;
  assign bus.M1_READ_DATA = rvalid_q[1] ? bus.S_READ_DATA : '0;

  assign bus.M0_GNT    = gnt_q[0];
  assign bus.M1_GNT    = gnt_q[1];
  assign bus.M0_WACK   = wack_q[0];
  assign bus.M1_WACK   = wack_q[1];
  assign bus.M0_RVALID = rvalid_q[0];
  assign bus.M1_RVALID = rvalid_q[1];
  assign bus.M0_DONE   = done_q[0];
  assign bus.M1_DONE   = done_q[1];
  assign bus.M0_ERR    = err_q[0];
  assign bus.M1_ERR    = err_q[1];

endmodule
